// File: rtl/hex_display_pkg.sv
// hex_display_pkg: shared constants and helpers for the hex display peripheral.
// Holds the register map offsets, CTRL field positions, the blank segment code,
// the active-low 7-segment table and a byte-lane merge helper for bus writes.
package hex_display_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  // Register word offsets
  localparam logic [1:0] REG_VALUE     = 2'd0;
  localparam logic [1:0] REG_CTRL      = 2'd1;
  localparam logic [1:0] REG_BLINK_DIV = 2'd2;
  localparam logic [1:0] REG_STATUS    = 2'd3;

  // CTRL field positions
  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_LZB_BIT   = 1;
  localparam int unsigned CTRL_DMASK_LSB = 8;
  localparam int unsigned CTRL_BMASK_LSB = 16;

  // All segments dark (active-low)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment codes, bit0 = seg a .. bit6 = seg g
  localparam logic [6:0] SEG_TABLE [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Replace only the byte lanes whose enable bit is set
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/hex_display_if.sv
// hex_display_if: Avalon-MM slave bus of the hex display peripheral.
//   avs_address[1:0]    word address
//   avs_read/avs_write  strobes (no waitrequest)
//   avs_writedata[31:0] write data, avs_byteenable[3:0] byte lanes
//   avs_readdata[31:0]  read data, valid one cycle after avs_read
interface hex_display_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_readdata
  );
endinterface

// File: rtl/hex_seg7_decode.sv
// hex_seg7_decode: combinational nibble to active-low 7-segment decoder.
//   nibble[3:0] hex digit, blank forces all segments dark, seg[6:0] g..a.
module hex_seg7_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  // Table lookup unless the digit is suppressed
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      seg = SEG_TABLE[nibble];
    end
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: Avalon-MM peripheral driving six active-low 7-segment digits.
//   clk, reset      clock and asynchronous active-high reset
//   avs             Avalon-MM slave bus (hex_display_if.slave)
//   hex_out[41:0]   {HEX5..HEX0}, 7 bits each, registered, 0 = segment lit
// Registers: VALUE (24-bit nibbles), CTRL (EN, LZB, digit/blink masks),
// BLINK_DIV (blink half-period, 0 disables), STATUS (blink PHASE, read-only).
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 50000000,
  parameter int unsigned BLINK_DIV_RST = 25000000
) (
  input  logic          clk,
  input  logic          reset,
  hex_display_if.slave  avs,
  output logic [41:0]   hex_out
);

  // Without a known clock rate there is no sensible blink period, so start disabled
  localparam logic [31:0] BLINK_DIV_INIT = (CLK_HZ == 0) ? 32'd0 : BLINK_DIV_RST[31:0];

  logic [23:0] value_r;
  logic        en_r;
  logic        lzb_r;
  logic [5:0]  digit_mask_r;
  logic [5:0]  blink_mask_r;
  logic [31:0] blink_div_r;
  logic [31:0] cnt_r;
  logic        phase_r;
  logic [31:0] readdata_r;
  logic [41:0] hex_r;

  logic [31:0] reg_image_s;
  logic [31:0] merged_s;
  logic        bdiv_wr_s;
  logic        zero_run_s;
  logic [5:0]  lzb_blank_s;
  logic [5:0]  lit_s;
  logic [41:0] seg_s;

  // Current read image of the addressed register, plus byte-lane merged write value
  always_comb begin
    reg_image_s = 32'h0000_0000;
    case (avs.avs_address)
      REG_VALUE:     reg_image_s = {8'h00, value_r};
      REG_CTRL:      reg_image_s = {10'h000, blink_mask_r, 2'b00, digit_mask_r,
                                    6'h00, lzb_r, en_r};
      REG_BLINK_DIV: reg_image_s = blink_div_r;
      REG_STATUS:    reg_image_s = {31'h0000_0000, phase_r};
      default:       reg_image_s = 32'h0000_0000;
    endcase
    merged_s  = be_merge(reg_image_s, avs.avs_writedata, avs.avs_byteenable);
    bdiv_wr_s = avs.avs_write && (avs.avs_address == REG_BLINK_DIV);
  end

  // Register file writes; STATUS is read-only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_r      <= 24'h00_0000;
      en_r         <= 1'b1;
      lzb_r        <= 1'b0;
      digit_mask_r <= 6'h3F;
      blink_mask_r <= 6'h00;
      blink_div_r  <= BLINK_DIV_INIT;
    end else if (avs.avs_write) begin
      case (avs.avs_address)
        REG_VALUE: value_r <= merged_s[23:0];
        REG_CTRL: begin
          en_r         <= merged_s[CTRL_EN_BIT];
          lzb_r        <= merged_s[CTRL_LZB_BIT];
          digit_mask_r <= merged_s[CTRL_DMASK_LSB +: 6];
          blink_mask_r <= merged_s[CTRL_BMASK_LSB +: 6];
        end
        REG_BLINK_DIV: blink_div_r <= merged_s;
        default: ;
      endcase
    end
  end

  // Blink prescaler: a BLINK_DIV write restarts the period with PHASE=1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r   <= 32'd0;
      phase_r <= 1'b1;
    end else if (bdiv_wr_s || (blink_div_r == 32'd0)) begin
      cnt_r   <= 32'd0;
      phase_r <= 1'b1;
    end else if (cnt_r == (blink_div_r - 32'd1)) begin
      cnt_r   <= 32'd0;
      phase_r <= ~phase_r;
    end else begin
      cnt_r   <= cnt_r + 32'd1;
    end
  end

  // Registered read data; holds between reads and sees pre-write state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_r <= 32'h0000_0000;
    end else if (avs.avs_read) begin
      readdata_r <= reg_image_s;
    end else begin
      readdata_r <= readdata_r;
    end
  end

  // Leading-zero blanking: digit i>0 blanks when nibbles i..5 are all zero
  always_comb begin
    lzb_blank_s = 6'h00;
    zero_run_s  = 1'b1;
    if (lzb_r) begin
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        zero_run_s     = zero_run_s & (value_r[4*i +: 4] == 4'h0);
        lzb_blank_s[i] = zero_run_s;
      end
    end else begin
      lzb_blank_s = 6'h00;
    end
    lit_s = {6{en_r}} & digit_mask_r & ~(blink_mask_r & {6{~phase_r}}) & ~lzb_blank_s;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    hex_seg7_decode u_dec (
      .nibble (value_r[4*g +: 4]),
      .blank  (~lit_s[g]),
      .seg    (seg_s[7*g +: 7])
    );
  end

  // Segment output register; reset darkens every digit immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_r <= {42{1'b1}};
    end else begin
      hex_r <= seg_s;
    end
  end

  assign hex_out          = hex_r;
  assign avs.avs_readdata = readdata_r;

endmodule
